dense_argmax: RTL and testbench
===============================

# dense_argmax

Classification back end placed directly downstream of `denseLayer`. It consumes the 11 signed Q1.3.12 logits that `denseLayer` emits for each 128-sample input frame. It tracks the running maximum and reports the winning modulation class index and its score once per frame. An optional top-2 margin output is available for confidence gating in later logic.

## Interface
Parameters:
- `N_CLASS`, 11: logits per frame.
- `DATA_W`, 16: logit width, signed two's complement [1 sign, 3 int, 12 frac].
- `IDX_W`, 4: class index width; must satisfy 2^IDX_W >= N_CLASS.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `din`, in, DATA_W: logit from `denseLayer` `dout`.
- `din_vld`, in, 1: high for each valid logit beat.
- `class_id`, out, IDX_W: index (0..N_CLASS-1) of the maximum logit in the last completed frame.
- `class_score`, out, DATA_W: value of that maximum logit.
- `class_vld`, out, 1: one-cycle pulse when `class_id` and `class_score` update.
- `frame_cnt`, out, 16: count of completed frames; wraps at 65535 -> 0.
- `margin`, out, DATA_W+1: max minus second max, unsigned, saturating. Present only with `DENSE_ARGMAX_TOP2_EN`.

## Operation
- Beat counter `beat` (IDX_W bits) counts accepted beats. A beat is accepted on any cycle with `din_vld`=1. Beats need not be contiguous; gaps of any length are allowed.
- On the first beat (`beat`==0): `best_val<=din`, `best_idx<=0`.
- On later beats: if `$signed(din) > $signed(best_val)`, update `best_val<=din` and `best_idx<=beat`.
- Comparison is strict, so ties keep the lowest index.
- On beat N_CLASS-1 the comparison includes the current `din`. The block then:
  - registers `class_id`/`class_score` from the final result, including that beat;
  - pulses `class_vld`;
  - increments `frame_cnt`;
  - returns `beat` to 0.
- States:
  - IDLE: `beat`==0. Goes to ACC on `din_vld`.
  - ACC: 0<`beat`<N_CLASS. Goes to DONE when the final beat is accepted.
  - DONE: single cycle in which `class_vld` is high. Goes to IDLE, or straight into a new frame if `din_vld`=1 in that cycle. A beat in DONE is the first beat of the next frame and is not dropped.
- Back-to-back frames with no gap are supported at one logit per clock.
- `class_id` and `class_score` hold their values between pulses.
- Reset:
  - all outputs go to 0;
  - `beat`, `best_val`, `best_idx` and `frame_cnt` clear;
  - a reset mid-frame discards the partial frame, and the next accepted beat is treated as beat 0.

## Timing
- Latency: `class_vld` is high in the cycle after the clock edge that accepts the N_CLASS-th beat, i.e. a one-cycle registered output.
- Throughput: one frame per N_CLASS accepted beats; no stall or backpressure (no ready signal).
- `class_id`, `class_score` and `frame_cnt` change only on the same edge that raises `class_vld`.
- Reset values: `class_id`=0, `class_score`=0, `class_vld`=0, `frame_cnt`=0, `margin`=0.

## Configuration
- `DENSE_ARGMAX_TOP2_EN` defined:
  - adds `second_val` tracking; a new max demotes the old max to second, and values that are not a new max but are > `second_val` replace it;
  - ties with the max become the second (margin 0);
  - `margin` = `best_val - second_val`, computed at DATA_W+1 bits, registered with `class_vld`.
- Undefined: the `margin` port and the second-max logic are absent; all other behaviour is identical.

## Structure
- Shared package `dense_pkg`: `DATA_W`, `N_CLASS`, `IDX_W` constants and a `logit_t` signed typedef. These are shared with `denseLayer` and its bench.
- No sub-module: a single flat always block for state/counter plus a compare datapath; 150-250 lines expected.

## Test plan
- Single frame with logits 0x0100 at idx 0..10, except idx 7 = 0x2000 -> `class_vld` pulse 1 cycle after the 11th beat, `class_id`=7, `class_score`=0x2000, `frame_cnt`=1.
- All-negative frame with values -1..-11 (0xFFFF descending) -> `class_id`=0, `class_score`=0xFFFF. Checks signed compare.
- Tie: idx 3 and idx 9 both 0x1000, others 0 -> `class_id`=3; with `DENSE_ARGMAX_TOP2_EN`, `margin`=0.
- Three frames back-to-back, no gaps, then frames separated by 1500-cycle gaps and random `din_vld` holes mid-frame -> one `class_vld` per 11 accepted beats, correct ids, `frame_cnt` 1,2,3...
- Assert `rst_n`=0 after 5 beats of a frame, release, then send a full frame with max at idx 10 -> no `class_vld` from the partial frame, `class_id`=10, `frame_cnt`=1.
- `DENSE_ARGMAX_TOP2_EN`: max 0x7FFF, second 0x8000 (most negative, all others equal) -> `margin`=0xFFFF (17-bit); max 0x3000, second 0x1000 -> `margin`=0x2000.

Source files
------------

// File: rtl/dense_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dense_pkg : constants and types shared by denseLayer and dense_argmax |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package dense_pkg;

  localparam int DATA_W  = 16;
  localparam int N_CLASS = 11;
  localparam int IDX_W   = 4;

  typedef logic signed [DATA_W-1:0] logit_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dense_argmax.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dense_argmax : per-frame argmax of denseLayer logits, optional top-2 |
// |                margin output enabled by DENSE_ARGMAX_TOP2_EN.        |
// | Revision     : 1.0  initial release                                  |
// +----------------------------------------------------------------------+
module dense_argmax #(
  parameter int N_CLASS = dense_pkg::N_CLASS,
  parameter int DATA_W  = dense_pkg::DATA_W,
  parameter int IDX_W   = dense_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic [IDX_W-1:0]  class_id,
  output logic [DATA_W-1:0] class_score,
  output logic              class_vld,
  output logic [15:0]       frame_cnt
`ifdef DENSE_ARGMAX_TOP2_EN
  ,
  output logic [DATA_W:0]   margin
`endif
);
  import dense_pkg::*;

  localparam logic [IDX_W-1:0] c_last_beat = IDX_W'(N_CLASS - 1);

  logic [1:0]               state_q, state_d;
  logic [IDX_W-1:0]         beat_q, beat_d;
  logic signed [DATA_W-1:0] best_val_q, best_val_d;
  logic [IDX_W-1:0]         best_idx_q, best_idx_d;
  logic [IDX_W-1:0]         class_id_q, class_id_d;
  logic [DATA_W-1:0]        class_score_q, class_score_d;
  logic [15:0]              frame_cnt_q, frame_cnt_d;

  logic signed [DATA_W-1:0] w_din;
  logic                     w_first, w_gt_best, w_frame_done;

  assign w_din        = $signed(din);
  assign w_first      = (beat_q == '0);
  assign w_gt_best    = (w_din > best_val_q);
  assign w_frame_done = din_vld && (beat_q == c_last_beat);

  // The final beat's comparison feeds the output registers directly through *_d.
  always_comb begin
    beat_d        = beat_q;
    best_val_d    = best_val_q;
    best_idx_d    = best_idx_q;
    class_id_d    = class_id_q;
    class_score_d = class_score_q;
    frame_cnt_d   = frame_cnt_q;
    if (din_vld) begin
      if (w_first || w_gt_best) begin
        best_val_d = w_din;
        best_idx_d = beat_q;
      end
      beat_d = w_frame_done ? '0 : beat_q + 1'b1;
    end
    if (w_frame_done) begin
      class_id_d    = best_idx_d;
      class_score_d = best_val_d;
      frame_cnt_d   = frame_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (din_vld) state_d = ST_ACC;
      ST_ACC:  if (w_frame_done) state_d = ST_DONE;
      ST_DONE: state_d = din_vld ? ST_ACC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      best_val_q    <= '0;
      best_idx_q    <= '0;
      class_id_q    <= '0;
      class_score_q <= '0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      best_val_q    <= best_val_d;
      best_idx_q    <= best_idx_d;
      class_id_q    <= class_id_d;
      class_score_q <= class_score_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign class_id    = class_id_q;
  assign class_score = class_score_q;
  assign class_vld   = (state_q == ST_DONE);
  assign frame_cnt   = frame_cnt_q;

`ifdef DENSE_ARGMAX_TOP2_EN
  localparam logic signed [DATA_W-1:0] c_logit_min = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] second_val_q, second_val_d;
  logic [DATA_W:0]          margin_q, margin_d;
  logic [DATA_W:0]          w_diff;

  // Ties with the max are not a new max, so they land in second (margin 0).
  always_comb begin
    second_val_d = second_val_q;
    if (din_vld) begin
      if (w_first)
        second_val_d = c_logit_min;
      else if (w_gt_best)
        second_val_d = best_val_q;
      else if (w_din > second_val_q)
        second_val_d = w_din;
    end
  end

  assign w_diff = {best_val_d[DATA_W-1], best_val_d} - {second_val_d[DATA_W-1], second_val_d};

  always_comb begin
    margin_d = margin_q;
    if (w_frame_done)
      margin_d = w_diff[DATA_W] ? '0 : w_diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_val_q <= '0;
      margin_q     <= '0;
    end else begin
      second_val_q <= second_val_d;
      margin_q     <= margin_d;
    end
  end

  assign margin = margin_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dense_argmax.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dense_argmax : scoreboard bench for dense_argmax, directed frames |
// | Revision        : 1.0  initial release                               |
// +----------------------------------------------------------------------+
module tb_dense_argmax;
  import dense_pkg::*;

  localparam int NC = dense_pkg::N_CLASS;

  typedef struct {
    logic [3:0]  id;
    logic [15:0] score;
    logic [15:0] fc;
    logic [16:0] marg;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        din_vld = 1'b0;
  logic [3:0]  class_id;
  logic [15:0] class_score;
  logic        class_vld;
  logic [15:0] frame_cnt;
`ifdef DENSE_ARGMAX_TOP2_EN
  logic [16:0] margin;
`endif

  dense_argmax dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_vld     (din_vld),
    .class_id    (class_id),
    .class_score (class_score),
    .class_vld   (class_vld),
    .frame_cnt   (frame_cnt)
`ifdef DENSE_ARGMAX_TOP2_EN
    ,
    .margin      (margin)
`endif
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [15:0] fr [NC];
  logic [15:0] efc = '0;
  logic [3:0]  hold_id = '0;
  logic [15:0] hold_score = '0;
  logic [15:0] hold_fc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per class_vld pulse; outputs must hold otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (class_vld) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vld: got class_vld=1 expected no pulse (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("vld_cycle", 32'(cyc), 32'(e.cyc));
          chk("class_id", 32'(class_id), 32'(e.id));
          chk("class_score", 32'(class_score), 32'(e.score));
          chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
`ifdef DENSE_ARGMAX_TOP2_EN
          chk("margin", 32'(margin), 32'(e.marg));
`endif
          hold_id    = e.id;
          hold_score = e.score;
          hold_fc    = e.fc;
        end
      end else begin
        chk("hold_id", 32'(class_id), 32'(hold_id));
        chk("hold_score", 32'(class_score), 32'(hold_score));
        chk("hold_fc", 32'(frame_cnt), 32'(hold_fc));
      end
    end
  end

  task automatic idle(input int n);
    din_vld = 1'b0;
    repeat (n) begin
      din = 16'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input bit holes, input logic [3:0] eid,
                            input logic [15:0] escore, input logic [16:0] emarg);
    exp_t e;
    for (int i = 0; i < NC; i++) begin
      if (holes) idle($urandom_range(0, 3));
      din     = fr[i];
      din_vld = 1'b1;
      if (i == NC - 1) begin
        efc     = efc + 16'd1;
        e.id    = eid;
        e.score = escore;
        e.fc    = efc;
        e.marg  = emarg;
        e.cyc   = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < NC; i++) fr[i] = v;
  endtask

  task automatic load(input int f);
    case (f)
      1: begin fill(16'h0100); fr[7] = 16'h2000; end
      2: for (int i = 0; i < NC; i++) fr[i] = 16'(-(i + 1));
      3: begin fill(16'h0000); fr[3] = 16'h1000; fr[9] = 16'h1000; end
      4: begin fill(16'h8000); fr[4] = 16'h7FFF; end
      5: begin fill(16'h0000); fr[5] = 16'h3000; fr[2] = 16'h1000; end
      6: for (int i = 0; i < NC; i++) fr[i] = 16'(i * 16);
      default: begin fill(16'hF000); fr[0] = 16'h0500; fr[10] = 16'h0500; end
    endcase
  endtask

  task automatic check_reset_outputs();
    chk("rst_class_id", 32'(class_id), 32'h0);
    chk("rst_class_score", 32'(class_score), 32'h0);
    chk("rst_class_vld", 32'(class_vld), 32'h0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
`ifdef DENSE_ARGMAX_TOP2_EN
    chk("rst_margin", 32'(margin), 32'h0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    idle(3);

    load(1); send_frame(1'b0, 4'd7, 16'h2000, 17'h01F00);
    idle(4);
    load(2); send_frame(1'b0, 4'd0, 16'hFFFF, 17'h00001);
    idle(4);
    load(3); send_frame(1'b0, 4'd3, 16'h1000, 17'h00000);
    idle(2);

    load(4); send_frame(1'b0, 4'd4, 16'h7FFF, 17'h0FFFF);
    load(5); send_frame(1'b0, 4'd5, 16'h3000, 17'h02000);
    load(7); send_frame(1'b0, 4'd0, 16'h0500, 17'h00000);
    idle(1500);

    load(1); send_frame(1'b1, 4'd7, 16'h2000, 17'h01F00);
    idle(1500);
    load(6); send_frame(1'b1, 4'd10, 16'h00A0, 17'h00010);
    idle(1500);
    load(5); send_frame(1'b1, 4'd5, 16'h3000, 17'h02000);
    idle(5);

    load(4);
    for (int i = 0; i < 5; i++) begin
      din = fr[i]; din_vld = 1'b1;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; din_vld = 1'b0;
    efc = '0; hold_id = '0; hold_score = '0; hold_fc = '0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    load(6); send_frame(1'b0, 4'd10, 16'h00A0, 17'h00010);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    idle(5);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
